uart_tx_scheduler: RTL

Sequencing and arbitration controller for the byte-serial UART sender. It shares one sender between `N_REQ` requesters using round-robin order. It generates the baud tick that steps the sender and frames each byte on the line as start bit, 8 data bits (LSB first, taken from the sender), then stop bit(s). It sits between the system's byte producers and the UART TX pin.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_gen.sv | 43 ++++
 rtl/uart_tx_scheduler.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit scheduler.
//   uart_state_t          : frame sequencing states (IDLE/START/DATA/STOP)
//   DATA_BITS             : payload bits per frame
//   FAULT_TICKS           : DATA ticks allowed before the sender is declared stuck
//   DEFAULT_CLKS_PER_BIT  : default baud divisor (50 MHz / 115200)
//   TICK_CNT_W            : width of the per-state bit-period counter
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS            = 8;
    localparam int FAULT_TICKS          = 9;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // Must hold FAULT_TICKS-1 (DATA) and STOP_BITS-1 (STOP).
    localparam int TICK_CNT_W = $clog2(FAULT_TICKS + 1);

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Bit-period divisor. Counts 0..CLKS_PER_BIT-1 while run is high and
// pulses tick on the last count of each period.
// Ports:
//   clk   in  : system clock
//   reset in  : asynchronous active-high reset
//   clear in  : synchronous clear of the counter (start of a new frame)
//   run   in  : counter advances while high
//   tick  out : one-cycle pulse per bit period while running
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (run) begin
            if (count_reg == LAST) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign tick = run && (count_reg == LAST);

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares one byte-serial UART sender between N_REQ requesters in
// round-robin order, paces the sender with a baud tick and frames each
// byte on the line as start bit, 8 data bits (LSB first), stop bit(s).
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   req[N_REQ]       : level requests, one per requester
//   req_data         : byte k at [8k+7:8k]
//   ack[N_REQ]       : one-hot pulse when a byte is latched
//   complete         : pulse at the end of the last stop bit
//   busy             : high whenever a frame is in progress
//   fault            : pulse when the sender never reports done
//   baud_tick        : one pulse per bit period, steps the sender
//   send_enable      : enable to the sender
//   data_to_send     : latched byte to the sender
//   sender_done      : done flag from the sender
//   sender_serial    : serial bit from the sender
//   tx               : UART line, idle high
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [DATA_BITS*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]           ack,
    output logic                       complete,
    output logic                       busy,
    output logic                       fault,
    output logic                       baud_tick,
    output logic                       send_enable,
    output logic [DATA_BITS-1:0]       data_to_send,
    input  logic                       sender_done,
    input  logic                       sender_serial,
    output logic                       tx
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [TICK_CNT_W-1:0] FAULT_LAST = TICK_CNT_W'(FAULT_TICKS - 1);
    localparam logic [TICK_CNT_W-1:0] STOP_LAST  = TICK_CNT_W'(STOP_BITS - 1);

    uart_state_t               state_reg, state_next;
    logic [TICK_CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [PTR_W-1:0]          rr_ptr_reg, rr_ptr_next;
    logic [DATA_BITS-1:0]      data_reg, data_next;
    logic [N_REQ-1:0]          ack_reg, ack_next;
    logic                      complete_reg, complete_next;
    logic                      fault_reg, fault_next;
    // Remembers that this frame timed out so its stop bit ends silently.
    logic                      faulted_reg, faulted_next;

    logic                      baud_clear;
    logic                      baud_run;
    logic                      tick;

    // ------------------------------------------------------------------
    // Request bytes as an array so the granted byte is a simple index.
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] req_bytes [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_bytes[gi] = req_data[DATA_BITS*gi +: DATA_BITS];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin search: first high request at or above rr_ptr, wrapping.
    // Scanning offsets from high to low lets the smallest offset win.
    // ------------------------------------------------------------------
    logic             grant_valid;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W:0]   cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr_reg} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(N_REQ)) begin
                cand = cand - (PTR_W+1)'(N_REQ);
            end
            if (req[cand[PTR_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Baud generator: runs for the whole frame, restarted on each grant.
    // ------------------------------------------------------------------
    assign baud_run = (state_reg != IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clear),
        .run   (baud_run),
        .tick  (tick)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            rr_ptr_reg   <= '0;
            data_reg     <= '0;
            ack_reg      <= '0;
            complete_reg <= 1'b0;
            fault_reg    <= 1'b0;
            faulted_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            rr_ptr_reg   <= rr_ptr_next;
            data_reg     <= data_next;
            ack_reg      <= ack_next;
            complete_reg <= complete_next;
            fault_reg    <= fault_next;
            faulted_reg  <= faulted_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Pulse outputs are registered so they line up with
    // the state change that causes them (ack with START entry, complete
    // with IDLE entry, fault with STOP entry).
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        rr_ptr_next   = rr_ptr_reg;
        data_next     = data_reg;
        ack_next      = '0;
        complete_next = 1'b0;
        fault_next    = 1'b0;
        faulted_next  = faulted_reg;
        baud_clear    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    data_next           = req_bytes[grant_idx];
                    ack_next[grant_idx] = 1'b1;
                    rr_ptr_next         = (grant_idx == PTR_W'(N_REQ - 1)) ?
                                          '0 : grant_idx + PTR_W'(1);
                    baud_clear          = 1'b1;
                    bit_cnt_next        = '0;
                    faulted_next        = 1'b0;
                    state_next          = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_cnt_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    // sender_done is the sender's registered flag, so here it
                    // reflects the previous period: data[7] has had its full bit.
                    if (sender_done) begin
                        bit_cnt_next = '0;
                        state_next   = STOP;
                    end else if (bit_cnt_reg == FAULT_LAST) begin
                        fault_next   = 1'b1;
                        faulted_next = 1'b1;
                        bit_cnt_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + TICK_CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_reg == STOP_LAST) begin
                        complete_next = !faulted_reg;
                        bit_cnt_next  = '0;
                        state_next    = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + TICK_CNT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Line and sender control decode straight from the state register so
    // an asynchronous reset returns the line to idle without a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        tx          = 1'b1;
        send_enable = 1'b0;
        unique case (state_reg)
            START: begin
                tx          = 1'b0;
                send_enable = 1'b1;
            end
            DATA: begin
                tx          = sender_serial;
                send_enable = 1'b1;
            end
            default: begin
                tx          = 1'b1;
                send_enable = 1'b0;
            end
        endcase
    end

    assign busy         = (state_reg != IDLE);
    assign baud_tick    = tick;
    assign ack          = ack_reg;
    assign complete     = complete_reg;
    assign fault        = fault_reg;
    assign data_to_send = data_reg;

endmodule
